// File: rtl/tych_core_lpbk.sv
// Store-and-forward RX->TX loopback: whole packets are buffered, only complete error-free ones are sent.
// First TX beat 2 cycles after the committing RX eop; RX has no backpressure, TX honours ready with a held output register.
module tych_core_lpbk #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lpbk_en,
  input  logic [DATA_W-1:0]          mac_0_rx_data,
  input  logic                       mac_0_rx_sop,
  input  logic                       mac_0_rx_eop,
  input  logic                       mac_0_rx_valid,
  input  logic                       mac_0_rx_error,
  output logic [DATA_W-1:0]          mac_0_tx_data,
  output logic                       mac_0_tx_sop,
  output logic                       mac_0_tx_eop,
  output logic                       mac_0_tx_valid,
  output logic                       mac_0_tx_error,
  output logic                       mac_0_tx_skip_crc,
  input  logic                       mac_0_tx_ready,
  output logic [CNT_W-1:0]           stat_fwd_pkts,
  output logic [CNT_W-1:0]           stat_drop_pkts,
  output logic [$clog2(DEPTH):0]     fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} rx_state_t;
  rx_state_t state, state_nxt;

  logic              run;
  logic [PW-1:0]     wr_ptr, wr_nxt, cmt_ptr, cmt_nxt, cmt_vis, rd_ptr, fetch_ptr;
  logic [DATA_W+1:0] mem [DEPTH];
  logic [DATA_W+1:0] rd_entry;
  logic              we, w_sop, ld, mid_pkt, tx_acc, full_wr, full_cmt;
  logic [AW-1:0]     waddr;
  logic [1:0]        drop_inc;

  assign mac_0_tx_error    = 1'b0;
  assign mac_0_tx_skip_crc = 1'b0;

  // Release of rst takes effect one edge late so the first beat lands on a clean cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  assign full_wr  = (wr_ptr - rd_ptr) == DEPTH_P;
  assign full_cmt = (cmt_ptr - rd_ptr) == DEPTH_P;

  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_ptr;
    cmt_nxt   = cmt_ptr;
    we        = 1'b0;
    waddr     = wr_ptr[AW-1:0];
    w_sop     = 1'b0;
    drop_inc  = 2'd0;
    if (run && mac_0_rx_valid) begin
      if (state == RECV && !mac_0_rx_sop) begin
        if (full_wr) begin
          wr_nxt    = cmt_ptr;
          drop_inc  = 2'd1;
          state_nxt = mac_0_rx_eop ? IDLE : DISCARD;
        end else begin
          we     = 1'b1;
          wr_nxt = wr_ptr + 1'b1;
          if (mac_0_rx_eop) begin
            state_nxt = IDLE;
            if (mac_0_rx_error) begin
              wr_nxt   = cmt_ptr;
              drop_inc = 2'd1;
            end else begin
              cmt_nxt = wr_ptr + 1'b1;
            end
          end
        end
      end else if (mac_0_rx_sop) begin
        // A sop while receiving abandons the unterminated packet; the new one restarts at cmt_ptr.
        if (state == RECV) begin
          drop_inc = 2'd1;
          wr_nxt   = cmt_ptr;
        end
        state_nxt = IDLE;
        if (lpbk_en) begin
          if (full_cmt) begin
            wr_nxt    = cmt_ptr;
            drop_inc  = drop_inc + 2'd1;
            state_nxt = mac_0_rx_eop ? IDLE : DISCARD;
          end else begin
            we        = 1'b1;
            waddr     = cmt_ptr[AW-1:0];
            w_sop     = 1'b1;
            wr_nxt    = cmt_ptr + 1'b1;
            state_nxt = mac_0_rx_eop ? IDLE : RECV;
            if (mac_0_rx_eop) begin
              if (mac_0_rx_error) begin
                wr_nxt   = cmt_ptr;
                drop_inc = drop_inc + 2'd1;
              end else begin
                cmt_nxt = cmt_ptr + 1'b1;
              end
            end
          end
        end
      end else if (state == DISCARD && mac_0_rx_eop) begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {w_sop, mac_0_rx_eop, mac_0_rx_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      cmt_ptr        <= '0;
      cmt_vis        <= '0;
      stat_drop_pkts <= '0;
    end else begin
      state          <= state_nxt;
      wr_ptr         <= wr_nxt;
      cmt_ptr        <= cmt_nxt;
      cmt_vis        <= cmt_ptr;
      stat_drop_pkts <= stat_drop_pkts + CNT_W'(drop_inc);
    end
  end

  // rd_ptr only moves on acceptance, so the beat held in the output register still occupies the FIFO.
  assign tx_acc    = mac_0_tx_valid & mac_0_tx_ready;
  assign fetch_ptr = rd_ptr + PW'(mac_0_tx_valid);
  assign rd_entry  = mem[fetch_ptr[AW-1:0]];
  assign ld        = run && (cmt_vis != fetch_ptr) && (!mac_0_tx_valid || mac_0_tx_ready)
                     && (lpbk_en || mid_pkt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_0_tx_data  <= '0;
      mac_0_tx_sop   <= 1'b0;
      mac_0_tx_eop   <= 1'b0;
      mac_0_tx_valid <= 1'b0;
      mid_pkt        <= 1'b0;
      rd_ptr         <= '0;
      stat_fwd_pkts  <= '0;
      fifo_level     <= '0;
    end else begin
      if (ld) begin
        mac_0_tx_sop   <= rd_entry[DATA_W+1];
        mac_0_tx_eop   <= rd_entry[DATA_W];
        mac_0_tx_data  <= rd_entry[DATA_W-1:0];
        mac_0_tx_valid <= 1'b1;
        mid_pkt        <= !rd_entry[DATA_W];
      end else if (tx_acc) begin
        mac_0_tx_sop   <= 1'b0;
        mac_0_tx_eop   <= 1'b0;
        mac_0_tx_data  <= '0;
        mac_0_tx_valid <= 1'b0;
      end
      if (tx_acc) rd_ptr <= rd_ptr + 1'b1;
      if (tx_acc && mac_0_tx_eop) stat_fwd_pkts <= stat_fwd_pkts + 1'b1;
      fifo_level <= wr_ptr - rd_ptr;
    end
  end
endmodule

// File: tb/tb_tych_core_lpbk.sv
// Directed bench for tych_core_lpbk: loopback, drops, overflow, lpbk_en gating and reset.
module tb_tych_core_lpbk;
  localparam int DATA_W = 512;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 32;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0, rst = 1'b0, lpbk_en = 1'b0;
  logic [DATA_W-1:0] mac_0_rx_data = '0;
  logic mac_0_rx_sop = 1'b0, mac_0_rx_eop = 1'b0, mac_0_rx_valid = 1'b0, mac_0_rx_error = 1'b0;
  logic [DATA_W-1:0] mac_0_tx_data;
  logic mac_0_tx_sop, mac_0_tx_eop, mac_0_tx_valid, mac_0_tx_error, mac_0_tx_skip_crc;
  logic mac_0_tx_ready = 1'b0;
  logic [CNT_W-1:0] stat_fwd_pkts, stat_drop_pkts;
  logic [LW-1:0] fifo_level;

  int total = 0;
  int bad = 0;
  logic [31:0] q_dat[$];
  logic        q_sop[$];
  logic        q_eop[$];

  tych_core_lpbk #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .lpbk_en(lpbk_en),
    .mac_0_rx_data(mac_0_rx_data), .mac_0_rx_sop(mac_0_rx_sop), .mac_0_rx_eop(mac_0_rx_eop),
    .mac_0_rx_valid(mac_0_rx_valid), .mac_0_rx_error(mac_0_rx_error),
    .mac_0_tx_data(mac_0_tx_data), .mac_0_tx_sop(mac_0_tx_sop), .mac_0_tx_eop(mac_0_tx_eop),
    .mac_0_tx_valid(mac_0_tx_valid), .mac_0_tx_error(mac_0_tx_error),
    .mac_0_tx_skip_crc(mac_0_tx_skip_crc), .mac_0_tx_ready(mac_0_tx_ready),
    .stat_fwd_pkts(stat_fwd_pkts), .stat_drop_pkts(stat_drop_pkts), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so at negedge valid&ready means acceptance at the next edge.
  always @(negedge clk) begin
    if (rst && mac_0_tx_valid && mac_0_tx_ready) begin
      q_dat.push_back(mac_0_tx_data[31:0]);
      q_sop.push_back(mac_0_tx_sop);
      q_eop.push_back(mac_0_tx_eop);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_q;
    q_dat.delete();
    q_sop.delete();
    q_eop.delete();
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e, input logic er);
    mac_0_rx_data = '0;
    mac_0_rx_data[31:0] = d;
    mac_0_rx_sop = s;
    mac_0_rx_eop = e;
    mac_0_rx_error = er;
    mac_0_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    mac_0_rx_valid = 1'b0;
    mac_0_rx_sop = 1'b0;
    mac_0_rx_eop = 1'b0;
    mac_0_rx_error = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cyc(3);
    total++;
    if ({mac_0_tx_valid, mac_0_tx_sop, mac_0_tx_eop, mac_0_tx_error, mac_0_tx_skip_crc} !== 5'b0) begin
      bad++;
      $display("FAIL reset_tx_ctl got=%b exp=00000",
               {mac_0_tx_valid, mac_0_tx_sop, mac_0_tx_eop, mac_0_tx_error, mac_0_tx_skip_crc});
    end
    total++;
    if ({mac_0_tx_data, stat_fwd_pkts, stat_drop_pkts, fifo_level} !== '0) begin
      bad++;
      $display("FAIL reset_data_cnt got fwd=%0d drop=%0d lvl=%0d exp all 0",
               stat_fwd_pkts, stat_drop_pkts, fifo_level);
    end
    rst = 1'b1;
    cyc(3);
  endtask

  task automatic test_basic;
    lpbk_en = 1'b1;
    mac_0_tx_ready = 1'b1;
    clr_q();
    for (int i = 1; i <= 4; i++) send(32'(i), i == 1, i == 4, 1'b0);
    total++;
    if (mac_0_tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_lat_e0 got=%b exp=0", mac_0_tx_valid);
    end
    cyc(1);
    total++;
    if (mac_0_tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_lat_e1 got=%b exp=0", mac_0_tx_valid);
    end
    cyc(1);
    total++;
    if ({mac_0_tx_valid, mac_0_tx_sop, mac_0_tx_data[31:0]} !== {1'b1, 1'b1, 32'h1}) begin
      bad++;
      $display("FAIL basic_lat_e2 got=%0h exp=%0h",
               {mac_0_tx_valid, mac_0_tx_sop, mac_0_tx_data[31:0]}, {1'b1, 1'b1, 32'h1});
    end
    cyc(8);
    total++;
    if (q_dat.size() != 4) begin
      bad++;
      $display("FAIL basic_count got=%0d exp=4", q_dat.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < q_dat.size()) begin
        total++;
        if ({q_sop[i], q_eop[i], q_dat[i]} !== {i == 0, i == 3, 32'(i + 1)}) begin
          bad++;
          $display("FAIL basic_beat%0d got=%0h exp=%0h", i, {q_sop[i], q_eop[i], q_dat[i]},
                   {i == 0, i == 3, 32'(i + 1)});
        end
      end
    end
    total++;
    if ({stat_fwd_pkts, stat_drop_pkts} !== {32'd1, 32'd0}) begin
      bad++;
      $display("FAIL basic_stats got fwd=%0d drop=%0d exp fwd=1 drop=0", stat_fwd_pkts, stat_drop_pkts);
    end
  endtask

  task automatic test_error;
    clr_q();
    send(32'h21, 1'b1, 1'b0, 1'b0);
    send(32'h22, 1'b0, 1'b0, 1'b0);
    send(32'h23, 1'b0, 1'b1, 1'b1);
    send(32'h31, 1'b1, 1'b0, 1'b0);
    send(32'h32, 1'b0, 1'b1, 1'b0);
    cyc(8);
    total++;
    if (q_dat.size() != 2) begin
      bad++;
      $display("FAIL err_count got=%0d exp=2", q_dat.size());
    end
    for (int i = 0; i < 2; i++) begin
      if (i < q_dat.size()) begin
        total++;
        if ({q_sop[i], q_eop[i], q_dat[i]} !== {i == 0, i == 1, 32'(32'h31 + i)}) begin
          bad++;
          $display("FAIL err_beat%0d got=%0h exp=%0h", i, {q_sop[i], q_eop[i], q_dat[i]},
                   {i == 0, i == 1, 32'(32'h31 + i)});
        end
      end
    end
    total++;
    if ({stat_fwd_pkts, stat_drop_pkts, fifo_level} !== {32'd2, 32'd1, 7'd0}) begin
      bad++;
      $display("FAIL err_stats got fwd=%0d drop=%0d lvl=%0d exp 2 1 0", stat_fwd_pkts, stat_drop_pkts, fifo_level);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] prev;
    logic pv, rdy;
    mac_0_tx_ready = 1'b0;
    clr_q();
    for (int i = 0; i < 40; i++) send(32'h101 + 32'(i), i == 0, i == 39, 1'b0);
    for (int i = 0; i < 30; i++) send(32'h201 + 32'(i), i == 0, i == 29, 1'b0);
    cyc(3);
    total++;
    if ({fifo_level, stat_drop_pkts} !== {7'd40, 32'd2}) begin
      bad++;
      $display("FAIL ovf_level got lvl=%0d drop=%0d exp lvl=40 drop=2", fifo_level, stat_drop_pkts);
    end
    total++;
    if ({mac_0_tx_valid, mac_0_tx_sop, mac_0_tx_data[31:0]} !== {1'b1, 1'b1, 32'h101}) begin
      bad++;
      $display("FAIL ovf_head got=%0h exp=%0h", {mac_0_tx_valid, mac_0_tx_sop, mac_0_tx_data[31:0]},
               {1'b1, 1'b1, 32'h101});
    end
    for (int i = 0; i < 120; i++) begin
      prev = mac_0_tx_data[31:0];
      pv = mac_0_tx_valid;
      rdy = (i % 2) == 1;
      mac_0_tx_ready = rdy;
      cyc(1);
      if (!rdy && pv) begin
        total++;
        if ({mac_0_tx_valid, mac_0_tx_data[31:0]} !== {1'b1, prev}) begin
          bad++;
          $display("FAIL ovf_stall%0d got=%0h exp=%0h", i, {mac_0_tx_valid, mac_0_tx_data[31:0]}, {1'b1, prev});
        end
      end
    end
    mac_0_tx_ready = 1'b1;
    cyc(4);
    total++;
    if (q_dat.size() != 40) begin
      bad++;
      $display("FAIL ovf_count got=%0d exp=40", q_dat.size());
    end
    for (int i = 0; i < 40; i++) begin
      if (i < q_dat.size()) begin
        total++;
        if ({q_sop[i], q_eop[i], q_dat[i]} !== {i == 0, i == 39, 32'h101 + 32'(i)}) begin
          bad++;
          $display("FAIL ovf_beat%0d got=%0h exp=%0h", i, {q_sop[i], q_eop[i], q_dat[i]},
                   {i == 0, i == 39, 32'h101 + 32'(i)});
        end
      end
    end
    total++;
    if ({stat_fwd_pkts, fifo_level} !== {32'd3, 7'd0}) begin
      bad++;
      $display("FAIL ovf_end got fwd=%0d lvl=%0d exp fwd=3 lvl=0", stat_fwd_pkts, fifo_level);
    end
  endtask

  task automatic test_missing_eop;
    clr_q();
    send(32'h51, 1'b1, 1'b0, 1'b0);
    send(32'h52, 1'b0, 1'b0, 1'b0);
    send(32'h61, 1'b1, 1'b0, 1'b0);
    send(32'h62, 1'b0, 1'b0, 1'b0);
    send(32'h63, 1'b0, 1'b1, 1'b0);
    cyc(8);
    total++;
    if (q_dat.size() != 3) begin
      bad++;
      $display("FAIL noeop_count got=%0d exp=3", q_dat.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < q_dat.size()) begin
        total++;
        if ({q_sop[i], q_eop[i], q_dat[i]} !== {i == 0, i == 2, 32'h61 + 32'(i)}) begin
          bad++;
          $display("FAIL noeop_beat%0d got=%0h exp=%0h", i, {q_sop[i], q_eop[i], q_dat[i]},
                   {i == 0, i == 2, 32'h61 + 32'(i)});
        end
      end
    end
    total++;
    if ({stat_fwd_pkts, stat_drop_pkts} !== {32'd4, 32'd3}) begin
      bad++;
      $display("FAIL noeop_stats got fwd=%0d drop=%0d exp fwd=4 drop=3", stat_fwd_pkts, stat_drop_pkts);
    end
  endtask

  task automatic test_lpbk_off;
    lpbk_en = 1'b0;
    clr_q();
    send(32'h71, 1'b1, 1'b0, 1'b0);
    send(32'h72, 1'b0, 1'b0, 1'b0);
    send(32'h73, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      total++;
      if ({mac_0_tx_valid, mac_0_tx_sop, mac_0_tx_eop, mac_0_tx_data} !== '0) begin
        bad++;
        $display("FAIL off_idle%0d got valid=%b data=%0h exp all 0", i, mac_0_tx_valid, mac_0_tx_data[31:0]);
      end
    end
    total++;
    if ({stat_fwd_pkts, stat_drop_pkts, fifo_level} !== {32'd4, 32'd3, 7'd0}) begin
      bad++;
      $display("FAIL off_stats got fwd=%0d drop=%0d lvl=%0d exp 4 3 0", stat_fwd_pkts, stat_drop_pkts, fifo_level);
    end
    lpbk_en = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h81 + 32'(i), i == 0, i == 3, 1'b0);
    cyc(2);
    lpbk_en = 1'b0;
    total++;
    if ({mac_0_tx_valid, mac_0_tx_sop} !== 2'b11) begin
      bad++;
      $display("FAIL off_mid_start got=%b exp=11", {mac_0_tx_valid, mac_0_tx_sop});
    end
    cyc(8);
    total++;
    if (q_dat.size() != 4) begin
      bad++;
      $display("FAIL off_mid_count got=%0d exp=4", q_dat.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < q_dat.size()) begin
        total++;
        if ({q_sop[i], q_eop[i], q_dat[i]} !== {i == 0, i == 3, 32'h81 + 32'(i)}) begin
          bad++;
          $display("FAIL off_mid_beat%0d got=%0h exp=%0h", i, {q_sop[i], q_eop[i], q_dat[i]},
                   {i == 0, i == 3, 32'h81 + 32'(i)});
        end
      end
    end
    total++;
    if ({stat_fwd_pkts, mac_0_tx_valid, mac_0_tx_data[31:0]} !== {32'd5, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL off_mid_end got fwd=%0d valid=%b exp fwd=5 valid=0", stat_fwd_pkts, mac_0_tx_valid);
    end
  endtask

  task automatic test_reset_mid;
    lpbk_en = 1'b1;
    mac_0_tx_ready = 1'b0;
    clr_q();
    for (int i = 0; i < 4; i++) send(32'h91 + 32'(i), i == 0, i == 3, 1'b0);
    send(32'hA1, 1'b1, 1'b0, 1'b0);
    send(32'hA2, 1'b0, 1'b0, 1'b0);
    total++;
    if ({mac_0_tx_valid, mac_0_tx_data[31:0]} !== {1'b1, 32'h91}) begin
      bad++;
      $display("FAIL rmid_pre got=%0h exp=%0h", {mac_0_tx_valid, mac_0_tx_data[31:0]}, {1'b1, 32'h91});
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({mac_0_tx_valid, mac_0_tx_sop, mac_0_tx_eop, mac_0_tx_data, stat_fwd_pkts, stat_drop_pkts, fifo_level} !== '0) begin
      bad++;
      $display("FAIL rmid_async got valid=%b fwd=%0d drop=%0d lvl=%0d exp all 0",
               mac_0_tx_valid, stat_fwd_pkts, stat_drop_pkts, fifo_level);
    end
    cyc(2);
    rst = 1'b1;
    cyc(3);
    mac_0_tx_ready = 1'b1;
    clr_q();
    send(32'hB1, 1'b1, 1'b0, 1'b0);
    send(32'hB2, 1'b0, 1'b1, 1'b0);
    cyc(8);
    total++;
    if (q_dat.size() != 2) begin
      bad++;
      $display("FAIL rmid_count got=%0d exp=2", q_dat.size());
    end
    for (int i = 0; i < 2; i++) begin
      if (i < q_dat.size()) begin
        total++;
        if ({q_sop[i], q_eop[i], q_dat[i]} !== {i == 0, i == 1, 32'hB1 + 32'(i)}) begin
          bad++;
          $display("FAIL rmid_beat%0d got=%0h exp=%0h", i, {q_sop[i], q_eop[i], q_dat[i]},
                   {i == 0, i == 1, 32'hB1 + 32'(i)});
        end
      end
    end
    total++;
    if ({stat_fwd_pkts, stat_drop_pkts, fifo_level} !== {32'd1, 32'd0, 7'd0}) begin
      bad++;
      $display("FAIL rmid_stats got fwd=%0d drop=%0d lvl=%0d exp 1 0 0", stat_fwd_pkts, stat_drop_pkts, fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_overflow();
    test_missing_eop();
    test_lpbk_off();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tych_core_lpbk.md
Name: tych_core_lpbk

Overview:
- Parametrised successor to the fixed, idle MAC core.
- Store-and-forward loopback between one MAC RX Avalon-ST stream and one MAC TX stream.
- Buffers whole packets in a beat FIFO and forwards only complete, error-free packets. Drops errored and oversize packets and counts them.
- With lpbk_en low it reproduces the legacy behaviour: TX held idle at all-zero outputs.

Parameters:
DATA_W, 512, data beat width in bits
DEPTH, 64, data FIFO depth in beats; power of 2, >= 4
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-low reset (asserted when 0)
lpbk_en  input  1  1 = loopback active; 0 = TX idle, RX discarded
mac_0_rx_data  input  DATA_W  RX beat data
mac_0_rx_sop  input  1  RX start of packet
mac_0_rx_eop  input  1  RX end of packet
mac_0_rx_valid  input  1  RX beat valid (no backpressure available)
mac_0_rx_error  input  1  RX packet error, meaningful on the eop beat
mac_0_tx_data  output  DATA_W  TX beat data
mac_0_tx_sop  output  1  TX start of packet
mac_0_tx_eop  output  1  TX end of packet
mac_0_tx_valid  output  1  TX beat valid
mac_0_tx_error  output  1  TX error, always 0
mac_0_tx_skip_crc  output  1  always 0 (MAC regenerates CRC)
mac_0_tx_ready  input  1  TX ready from MAC
stat_fwd_pkts  output  CNT_W  packets fully transmitted, wraps
stat_drop_pkts  output  CNT_W  packets dropped, wraps
fifo_level  output  $clog2(DEPTH)+1  beats currently stored (committed plus in-progress)

Behaviour:
- Reset (rst=0, async): all outputs 0, pointers 0, RX FSM in IDLE, TX output register empty. Release is synchronised internally; first RX beat is accepted on the second clk edge after release.
- Pointers: wr_ptr (speculative), cmt_ptr (committed), rd_ptr. Each is $clog2(DEPTH)+1 bits and wraps modulo 2*DEPTH. Full when wr_ptr - rd_ptr == DEPTH.
- RX FSM states: IDLE, RECV, DISCARD.
  - IDLE: valid&sop&lpbk_en: write beat, go RECV (or stay IDLE and commit if eop also set, subject to the error check). Valid without sop is ignored. lpbk_en=0: beats ignored, not counted.
  - RECV: each valid beat is written, wr_ptr++.
    - eop with error=0: cmt_ptr<=wr_ptr+1, go IDLE.
    - eop with error=1: wr_ptr<=cmt_ptr, stat_drop_pkts++, go IDLE.
  - Beat arriving while full: wr_ptr<=cmt_ptr, stat_drop_pkts++. Go DISCARD, or IDLE if that beat is eop.
  - sop received in RECV (missing eop): current packet rewound and dropped (stat_drop_pkts++). New packet starts at cmt_ptr on the same beat.
  - DISCARD: ignore beats until eop, then IDLE. A sop in DISCARD starts a new packet as in IDLE.
  - lpbk_en is sampled only at sop. Deassertion mid-packet does not abort the RX packet.
- TX path:
  - One-entry registered output stage fed from FIFO reads of beats in [rd_ptr, cmt_ptr).
  - First beat of a committed packet appears with tx_valid=1 two cycles after the committing eop beat's clk edge, provided TX was idle.
  - data/sop/eop held stable while valid&!ready. Throughput is 1 beat/cycle while ready=1, with no bubbles within or between committed packets.
  - sop/eop on TX are regenerated from stored per-beat flags.
  - stat_fwd_pkts++ on the cycle a tx eop beat is accepted (valid&ready).
  - With lpbk_en=0 and no packet in flight on TX: tx_valid=0 and all TX fields 0. A TX packet already started always completes.
- Simultaneous RX commit and TX read in the same cycle are both honoured. fifo_level = wr_ptr - rd_ptr, updated on the following cycle.
- Packets longer than DEPTH beats are always dropped.

Test Plan:
- Reset, lpbk_en=1, RX 4-beat packet (data 0x1..0x4), tx_ready=1 -> TX emits 0x1..0x4 with sop on beat 1, eop on beat 4; first tx_valid 2 cycles after RX eop; stat_fwd_pkts=1, stat_drop_pkts=0.
- RX 3-beat packet with error=1 on eop, followed by a good 2-beat packet -> only the 2-beat packet is transmitted; stat_drop_pkts=1, fifo_level returns to 0.
- DEPTH=64, tx_ready=0, RX 40-beat then 30-beat packets -> first committed (fifo_level=40), second overflows at beat 25 and is dropped (drop=1). Raising ready transmits exactly the 40 beats, with data stable across stalls.
- RX sop, 2 beats, then a new sop without eop, new packet of 3 beats -> first dropped, second (3 beats) transmitted; stat_drop_pkts=1.
- lpbk_en=0 with RX traffic -> TX all-zero, counters unchanged. Deassert lpbk_en mid-TX packet -> that packet completes, then TX idles.
- Assert rst mid-packet on both RX and TX -> outputs zero immediately (asynchronously); after release, a fresh packet loops back correctly and counters restart from 0.
